nios_debug_scan_bridge: RTL and testbench
=========================================

Name: nios_debug_scan_bridge

Overview:
Parametrised, single-clock successor to the Nios II debug-slave command path.
- Receives a virtual scan chain (capture/shift/update strobes, IR code, serial TDI) already synchronised into the system clock domain.
- Presents each updated scan word to the CPU debug logic as a valid/ready command.
- Generates per-IR take_action / take_no_action pulses.
- Captures per-IR readback data plus overrun/pending status back into the chain.

Parameters:
DATA_W, 38, scan register width; MSB is the action bit, bits [DATA_W-3:0] are payload.
IR_W, 2, instruction register width; NUM_IR = 2**IR_W command channels.
PAY_W, DATA_W-2, readback payload width per channel (derived, not overridable).

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ir_in  in  IR_W  current scan instruction
vs_capture  in  1  capture strobe, one clk cycle
vs_shift  in  1  shift-enable, one bit per asserted cycle
vs_update  in  1  update strobe, one clk cycle
tdi  in  1  serial data in
tdo  out  1  serial data out (= sr[0])
rd_data  in  NUM_IR*PAY_W  flattened readback; channel k at [k*PAY_W +: PAY_W]
cmd_valid  out  1  command held for CPU
cmd_ready  in  1  CPU accepts command
cmd_ir  out  IR_W  IR of held command
jdo  out  DATA_W  held scan word
take_action  out  NUM_IR  one-cycle pulse, held command had action bit = 1
take_no_action  out  NUM_IR  one-cycle pulse, held command had action bit = 0
overrun  out  1  sticky: an update was dropped

Behaviour:
- Reset (synchronous, active-high): sr, jdo, cmd_ir, cmd_valid, take_action, take_no_action and overrun all go to 0. tdo follows sr[0], so it is 0. A reset asserted mid-shift or mid-handshake discards everything.
- Scan register sr, per cycle, with priority capture > shift > hold:
  - vs_capture: sr <= {overrun, cmd_valid, rd_data[ir_in]}.
  - vs_shift: sr <= {tdi, sr[DATA_W-1:1]}.
  - vs_update never modifies sr.
  - If vs_capture and vs_shift are asserted in the same cycle, capture wins.
- Command holding register:
  - vs_update && !cmd_valid: jdo <= sr; cmd_ir <= ir_in; cmd_valid <= 1 on the next edge.
  - accept = cmd_valid && cmd_ready. On accept, cmd_valid <= 0 unless vs_update is asserted in the same cycle. In that case the new word is loaded, cmd_valid stays 1, and no overrun is raised.
  - vs_update && cmd_valid && !cmd_ready: word dropped, jdo/cmd_ir unchanged, overrun <= 1.
  - jdo and cmd_ir are stable while cmd_valid=1 and no accept occurs.
- Pulses:
  - On the cycle after an accept, exactly one bit fires: take_action[cmd_ir] if jdo[DATA_W-1]=1, else take_no_action[cmd_ir].
  - The pulse uses the values registered at accept time. Latency is 1 cycle after accept.
  - All other bits are 0. Pulses are never asserted on consecutive cycles unless accepts occur on consecutive cycles.
- Overrun:
  - Sticky; cleared only by vs_capture, after its value has been sampled into sr[DATA_W-1].
  - If a drop and a capture happen in the same cycle, overrun ends at 1 and the captured bit reflects the pre-cycle value.
- Width rules: rd_data channel select is ir_in indexed into the flattened bus. No truncation; PAY_W+2 == DATA_W always.

Decomposition:
- Shared package nios_debug_pkg:
  - IR code constants: IR_OCIMEM_A=0, IR_OCIMEM_B=1, IR_TRACECTRL=2, IR_BREAK=3.
  - Status bit positions: SR_OVERRUN=DATA_W-1, SR_PENDING=DATA_W-2.
  - Helper function computing PAY_W.
- One natural sub-module, nios_debug_scan_sr: the capture/shift register with the rd_data mux and tdo. The top holds the command register, handshake, pulse generation and overrun logic.

Test Plan:
- Reset, then shift 38 bits 0x2_0000_00A5 (action=1) with ir_in=1, then update; hold cmd_ready=1 -> cmd_valid rises the cycle after update, jdo=0x20000000A5, take_action=4'b0010 for exactly one cycle after accept.
- Same as above with MSB=0 and ir_in=3 -> take_no_action=4'b1000, take_action stays 0.
- rd_data channel 2 = 0x123456789, ir_in=2, cmd_valid=1, overrun=0, capture, then shift 38 cycles -> tdo serial stream LSB-first = 0x1123456789 (bit36=pending=1, bit37=0).
- cmd_ready=0, two updates with different words -> jdo keeps the first word, overrun=1; the next capture loads bit37=1 and clears overrun to 0 on the following cycle.
- Update in the same cycle as accept -> second word loaded, cmd_valid stays 1, overrun stays 0, one pulse for the first command.
- Assert reset during shift, and separately with cmd_valid=1 -> all outputs 0 on the next edge, and no pulse follows.

Source files
------------

// File: rtl/nios_debug_pkg.sv
// Shared constants and helpers for the Nios II debug scan bridge.
// IR codes, status bit positions and derived widths.
package nios_debug_pkg;

  localparam int DATA_W_DEF = 38;
  localparam int IR_W_DEF   = 2;

  localparam logic [1:0] IR_OCIMEM_A  = 2'd0;
  localparam logic [1:0] IR_OCIMEM_B  = 2'd1;
  localparam logic [1:0] IR_TRACECTRL = 2'd2;
  localparam logic [1:0] IR_BREAK     = 2'd3;

  localparam int SR_OVERRUN = DATA_W_DEF - 1;
  localparam int SR_PENDING = DATA_W_DEF - 2;

  // Readback payload excludes the overrun and pending status bits.
  function automatic int pay_w(input int data_w);
    return data_w - 2;
  endfunction

endpackage

// File: rtl/nios_debug_scan_bridge_if.sv
// Command handshake between the scan bridge and CPU debug logic.
// master drives the held word; slave accepts it.
interface nios_debug_cmd_if #(
  parameter int DATA_W = 38,
  parameter int IR_W   = 2
) ();

  logic              cmd_valid;
  logic              cmd_ready;
  logic [IR_W-1:0]   cmd_ir;
  logic [DATA_W-1:0] jdo;

  modport master (
    output cmd_valid,
    output cmd_ir,
    output jdo,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid,
    input  cmd_ir,
    input  jdo,
    output cmd_ready
  );

endinterface

// File: rtl/nios_debug_scan_sr.sv
// Virtual scan register: capture of status plus readback, serial shift.
// Capture has priority over shift; tdo is the register LSB.
module nios_debug_scan_sr
  import nios_debug_pkg::*;
#(
  parameter  int DATA_W = 38,
  parameter  int IR_W   = 2,
  localparam int NUM_IR = 2 ** IR_W,
  localparam int PAY_W  = pay_w(DATA_W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IR_W-1:0]         ir_i,
  input  logic                    capture_i,
  input  logic                    shift_i,
  input  logic                    tdi_i,
  input  logic                    ovr_i,
  input  logic                    pend_i,
  input  logic [NUM_IR*PAY_W-1:0] rd_data_i,
  output logic [DATA_W-1:0]       sr_o,
  output logic                    tdo_o
);

  logic [DATA_W-1:0] sr_q, sr_d;
  logic [PAY_W-1:0]  rd_sel;

  assign rd_sel = rd_data_i[ir_i*PAY_W +: PAY_W];

  // Next scan contents: capture beats shift, otherwise hold.
  always_comb begin
    sr_d = sr_q;
    if (capture_i) begin
      sr_d = {ovr_i, pend_i, rd_sel};
    end else if (shift_i) begin
      sr_d = {tdi_i, sr_q[DATA_W-1:1]};
    end
  end

  // Scan register state.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_q <= '0;
    end else begin
      sr_q <= sr_d;
    end
  end

  assign sr_o  = sr_q;
  assign tdo_o = sr_q[0];

endmodule

// File: rtl/nios_debug_scan_bridge.sv
// Scan-to-command bridge: holds updated scan words for the CPU,
// emits per-IR action pulses and tracks dropped updates.
module nios_debug_scan_bridge
  import nios_debug_pkg::*;
#(
  parameter  int DATA_W = 38,
  parameter  int IR_W   = 2,
  localparam int NUM_IR = 2 ** IR_W,
  localparam int PAY_W  = pay_w(DATA_W)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [IR_W-1:0]         ir_in,
  input  logic                    vs_capture,
  input  logic                    vs_shift,
  input  logic                    vs_update,
  input  logic                    tdi,
  output logic                    tdo,
  input  logic [NUM_IR*PAY_W-1:0] rd_data,
  nios_debug_cmd_if.master        cmd,
  output logic [NUM_IR-1:0]       take_action,
  output logic [NUM_IR-1:0]       take_no_action,
  output logic                    overrun
);

  logic [DATA_W-1:0] sr;
  logic [DATA_W-1:0] jdo_q, jdo_d;
  logic [IR_W-1:0]   cmd_ir_q, cmd_ir_d;
  logic              cmd_valid_q, cmd_valid_d;
  logic              overrun_q, overrun_d;
  logic [NUM_IR-1:0] ta_q, ta_d;
  logic [NUM_IR-1:0] tna_q, tna_d;
  logic              accept, load, drop;

  nios_debug_scan_sr #(
    .DATA_W (DATA_W),
    .IR_W   (IR_W)
  ) u_sr (
    .clk       (clk),
    .reset     (reset),
    .ir_i      (ir_in),
    .capture_i (vs_capture),
    .shift_i   (vs_shift),
    .tdi_i     (tdi),
    .ovr_i     (overrun_q),
    .pend_i    (cmd_valid_q),
    .rd_data_i (rd_data),
    .sr_o      (sr),
    .tdo_o     (tdo)
  );

  assign accept = cmd_valid_q && cmd.cmd_ready;
  assign load   = vs_update && (!cmd_valid_q || accept);
  assign drop   = vs_update && cmd_valid_q && !cmd.cmd_ready;

  // Command holding register and sticky overrun next state.
  always_comb begin
    jdo_d       = jdo_q;
    cmd_ir_d    = cmd_ir_q;
    cmd_valid_d = cmd_valid_q;
    overrun_d   = overrun_q;
    if (load) begin
      jdo_d       = sr;
      cmd_ir_d    = ir_in;
      cmd_valid_d = 1'b1;
    end else if (accept) begin
      cmd_valid_d = 1'b0;
    end
    if (drop) begin
      overrun_d = 1'b1;
    end else if (vs_capture) begin
      overrun_d = 1'b0;
    end
  end

  // One-hot pulse for the command being accepted this cycle.
  always_comb begin
    ta_d  = '0;
    tna_d = '0;
    if (accept) begin
      if (jdo_q[DATA_W-1]) begin
        ta_d[cmd_ir_q] = 1'b1;
      end else begin
        tna_d[cmd_ir_q] = 1'b1;
      end
    end
  end

  // Command, status and pulse registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      jdo_q       <= '0;
      cmd_ir_q    <= '0;
      cmd_valid_q <= 1'b0;
      overrun_q   <= 1'b0;
      ta_q        <= '0;
      tna_q       <= '0;
    end else begin
      jdo_q       <= jdo_d;
      cmd_ir_q    <= cmd_ir_d;
      cmd_valid_q <= cmd_valid_d;
      overrun_q   <= overrun_d;
      ta_q        <= ta_d;
      tna_q       <= tna_d;
    end
  end

  assign cmd.cmd_valid   = cmd_valid_q;
  assign cmd.cmd_ir      = cmd_ir_q;
  assign cmd.jdo         = jdo_q;
  assign take_action     = ta_q;
  assign take_no_action  = tna_q;
  assign overrun         = overrun_q;

endmodule

// File: tb/tb_nios_debug_scan_bridge.sv
// Self-checking bench for nios_debug_scan_bridge.
// Directed scenarios plus random traffic against a behavioural model.
module tb_nios_debug_scan_bridge;
  import nios_debug_pkg::*;

  localparam int DW = 38;
  localparam int IW = 2;
  localparam int NI = 4;
  localparam int PW = 36;

  logic          clk = 1'b0;
  logic          reset;
  logic [IW-1:0] ir_in;
  logic          vs_capture, vs_shift, vs_update, tdi;
  logic          tdo;
  logic [NI*PW-1:0] rd_data;
  logic [NI-1:0] take_action, take_no_action;
  logic          overrun;

  nios_debug_cmd_if #(.DATA_W(DW), .IR_W(IW)) cmd_if ();

  nios_debug_scan_bridge #(.DATA_W(DW), .IR_W(IW)) dut (
    .clk            (clk),
    .reset          (reset),
    .ir_in          (ir_in),
    .vs_capture     (vs_capture),
    .vs_shift       (vs_shift),
    .vs_update      (vs_update),
    .tdi            (tdi),
    .tdo            (tdo),
    .rd_data        (rd_data),
    .cmd            (cmd_if.master),
    .take_action    (take_action),
    .take_no_action (take_no_action),
    .overrun        (overrun)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference state: scan word, held command, status and pulses.
  logic [DW-1:0] m_sr, m_jdo;
  logic [IW-1:0] m_ir;
  logic          m_valid, m_ovr;
  logic [NI-1:0] m_ta, m_tna;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock of the reference behaviour, using pre-edge values.
  task automatic model_step();
    logic          acc;
    logic [DW-1:0] sr_old;
    logic [PW-1:0] chan;
    if (reset) begin
      m_sr = '0; m_jdo = '0; m_ir = '0;
      m_valid = 0; m_ovr = 0; m_ta = '0; m_tna = '0;
      return;
    end
    acc    = m_valid && cmd_if.cmd_ready;
    sr_old = m_sr;
    chan   = rd_data[int'(ir_in)*PW +: PW];
    m_ta  = '0;
    m_tna = '0;
    if (acc) begin
      if (m_jdo[DW-1]) m_ta[m_ir] = 1'b1;
      else             m_tna[m_ir] = 1'b1;
    end
    if (vs_capture)
      m_sr = {m_ovr, m_valid, chan};
    else if (vs_shift)
      m_sr = {tdi, sr_old[DW-1:1]};
    if (vs_update && m_valid && !acc) begin
      m_ovr = 1'b1;
    end else begin
      if (vs_capture) m_ovr = 1'b0;
      if (vs_update) begin
        m_jdo = sr_old; m_ir = ir_in; m_valid = 1'b1;
      end else if (acc) begin
        m_valid = 1'b0;
      end
    end
  endtask

  task automatic compare_all();
    chk("tdo", 64'(tdo), 64'(m_sr[0]));
    chk("cmd_valid", 64'(cmd_if.cmd_valid), 64'(m_valid));
    chk("cmd_ir", 64'(cmd_if.cmd_ir), 64'(m_ir));
    chk("jdo", 64'(cmd_if.jdo), 64'(m_jdo));
    chk("take_action", 64'(take_action), 64'(m_ta));
    chk("take_no_action", 64'(take_no_action), 64'(m_tna));
    chk("overrun", 64'(overrun), 64'(m_ovr));
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle();
    vs_capture = 0; vs_shift = 0; vs_update = 0; tdi = 0;
  endtask

  task automatic shift_word(input logic [DW-1:0] w);
    for (int i = 0; i < DW; i++) begin
      vs_shift = 1; tdi = w[i];
      tick();
    end
    idle();
  endtask

  task automatic update(input logic [IW-1:0] ir);
    ir_in = ir; vs_update = 1;
    tick();
    vs_update = 0;
  endtask

  logic [DW-1:0] w1, w2, got;

  initial begin
    reset = 1; ir_in = '0; rd_data = '0;
    cmd_if.cmd_ready = 0;
    idle();
    @(negedge clk);
    tick(); tick();
    chk("rst_valid", 64'(cmd_if.cmd_valid), 64'd0);
    chk("rst_tdo", 64'(tdo), 64'd0);
    reset = 0;

    // Action command on channel 1.
    cmd_if.cmd_ready = 1;
    w1 = 38'h20000000A5;
    shift_word(w1);
    update(IR_OCIMEM_B);
    chk("t1_valid", 64'(cmd_if.cmd_valid), 64'd1);
    chk("t1_jdo", 64'(cmd_if.jdo), 64'h20000000A5);
    tick();
    chk("t1_ta", 64'(take_action), 64'b0010);
    chk("t1_tna", 64'(take_no_action), 64'd0);
    tick();
    chk("t1_ta_off", 64'(take_action), 64'd0);

    // No-action command on channel 3.
    shift_word(38'h00000000A5);
    update(IR_BREAK);
    tick();
    chk("t2_tna", 64'(take_no_action), 64'b1000);
    chk("t2_ta", 64'(take_action), 64'd0);
    tick();

    // Capture readback with a pending command, then shift it out.
    cmd_if.cmd_ready = 0;
    shift_word(38'h1111111111);
    update(IR_OCIMEM_A);
    rd_data[2*PW +: PW] = 36'h123456789;
    ir_in = IR_TRACECTRL; vs_capture = 1;
    tick();
    idle();
    got = '0;
    for (int i = 0; i < DW; i++) begin
      got[i] = tdo;
      vs_shift = 1; tdi = 0;
      tick();
    end
    idle();
    chk("t3_stream", 64'(got), 64'h1123456789);

    // Two updates while stalled: first kept, overrun set.
    w2 = 38'h0ABCDEF012;
    shift_word(w2);
    update(IR_BREAK);
    shift_word(38'h3333333333);
    update(IR_OCIMEM_B);
    chk("t4_jdo", 64'(cmd_if.jdo), 64'h1111111111);
    chk("t4_ovr", 64'(overrun), 64'd1);
    vs_capture = 1;
    tick();
    idle();
    chk("t4_sr_ovr", 64'(dut.sr[SR_OVERRUN]), 64'd1);
    chk("t4_ovr_clr", 64'(overrun), 64'd0);

    // Update coincident with accept.
    w1 = 38'h2000000001;
    shift_word(w1);
    cmd_if.cmd_ready = 1;
    update(IR_TRACECTRL);
    cmd_if.cmd_ready = 0;
    chk("t5_valid", 64'(cmd_if.cmd_valid), 64'd1);
    chk("t5_jdo", 64'(cmd_if.jdo), 64'(w1));
    chk("t5_ovr", 64'(overrun), 64'd0);
    chk("t5_pulse", 64'(take_no_action), 64'b0001);
    tick();
    chk("t5_quiet", 64'({take_action, take_no_action}), 64'd0);

    // Reset mid-shift and mid-handshake.
    vs_shift = 1; tdi = 1;
    tick();
    cmd_if.cmd_ready = 1; reset = 1;
    tick();
    reset = 0; idle();
    chk("t6_valid", 64'(cmd_if.cmd_valid), 64'd0);
    tick();
    chk("t6_nopulse", 64'({take_action, take_no_action}), 64'd0);

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      reset      = ($urandom_range(0, 199) == 0);
      ir_in      = IW'($urandom);
      vs_capture = ($urandom_range(0, 9) == 0);
      vs_shift   = ($urandom_range(0, 2) != 0);
      vs_update  = ($urandom_range(0, 7) == 0);
      tdi        = 1'($urandom);
      cmd_if.cmd_ready = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 15) == 0)
        for (int k = 0; k < NI * PW / 32 + 1; k++)
          rd_data = {rd_data[NI*PW-33:0], 32'($urandom)};
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
